// File: rtl/cond_pkg.sv
// Shared encodings for the condition/flag path: ARM condition codes,
// NZCV bit positions and flag-write group selects.
package cond_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_t;

   localparam int N_IDX = 3;
   localparam int Z_IDX = 2;
   localparam int C_IDX = 1;
   localparam int V_IDX = 0;

   localparam int FW_NZ = 1;
   localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (cond, NZCV) -> pass.
// Kept standalone so the branch predictor can reuse it.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[N_IDX];
   assign z = flags[Z_IDX];
   assign c = flags[C_IDX];
   assign v = flags[V_IDX];

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pass = 1'b1;
      case (cond_t'(cond))
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         COND_NV: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_flags_unit.sv
// Architectural NZCV register with shadow copy, condition gating of decoder enables.
// Optional COND_STATS_EN adds executed/skipped instruction counters (CNT_W wide).
module cond_flags_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             n_reset,
  input  logic             valid,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pc_s,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  input  logic             save_flags,
  input  logic             restore_flags,
  output logic             cond_ex,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic [3:0]       flags,
`ifdef COND_STATS_EN
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count,
`endif
  output logic [3:0]       saved_flags
);

  logic       live;
  logic       pass;
  logic [3:0] flags_d, flags_q;
  logic [3:0] saved_d, saved_q;

  cond_check u_cond_check (
    .cond  (cond),
    .flags (flags_q),
    .pass  (pass)
  );

  assign live      = valid & ~flush;
  assign cond_ex   = live & pass;
  assign pc_src    = pc_s & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;
  assign mem_write = mem_w & cond_ex;

  always_comb begin
    flags_d = flags_q;
    saved_d = saved_q;
    // Restore takes priority over both the ALU update and a same-cycle save.
    if (restore_flags) begin
      flags_d = saved_q;
    end else begin
      if (save_flags) saved_d = flags_q;
      if (cond_ex && flag_w[FW_NZ]) begin
        flags_d[N_IDX] = alu_flags[N_IDX];
        flags_d[Z_IDX] = alu_flags[Z_IDX];
      end
      if (cond_ex && flag_w[FW_CV]) begin
        flags_d[C_IDX] = alu_flags[C_IDX];
        flags_d[V_IDX] = alu_flags[V_IDX];
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!n_reset) begin
      flags_q <= 4'b0000;
      saved_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
    end
  end

  assign flags       = flags_q;
  assign saved_flags = saved_q;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_d, exec_q;
  logic [CNT_W-1:0] skip_d, skip_q;

  always_comb begin
    exec_d = exec_q + CNT_W'(cond_ex);
    skip_d = skip_q + CNT_W'(live & ~pass);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      exec_q <= '0;
      skip_q <= '0;
    end else begin
      exec_q <= exec_d;
      skip_q <= skip_d;
    end
  end

  assign exec_count = exec_q;
  assign skip_count = skip_q;
`endif

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit: directed sequences, a condition
// table and randomized traffic against an architectural reference model.
module tb_cond_flags_unit;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       valid, flush, pc_s, reg_w, mem_w, no_write, save_flags, restore_flags;
  logic [3:0] cond, alu_flags;
  logic [1:0] flag_w;
  logic       cond_ex, pc_src, reg_write, mem_write;
  logic [3:0] flags, saved_flags;
`ifdef COND_STATS_EN
  logic [CW-1:0] exec_count, skip_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  cond_flags_unit #(.CNT_W(CW)) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .valid         (valid),
    .flush         (flush),
    .cond          (cond),
    .alu_flags     (alu_flags),
    .flag_w        (flag_w),
    .pc_s          (pc_s),
    .reg_w         (reg_w),
    .mem_w         (mem_w),
    .no_write      (no_write),
    .save_flags    (save_flags),
    .restore_flags (restore_flags),
    .cond_ex       (cond_ex),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_write     (mem_write),
    .flags         (flags),
`ifdef COND_STATS_EN
    .exec_count    (exec_count),
    .skip_count    (skip_count),
`endif
    .saved_flags   (saved_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    valid = 0; flush = 0; cond = 4'hE; alu_flags = 0; flag_w = 0;
    pc_s = 0; reg_w = 0; mem_w = 0; no_write = 0; save_flags = 0; restore_flags = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads flags through a normal AL instruction updating both groups.
  task automatic load_flags(input logic [3:0] f);
    idle();
    valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = f;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    #1 n_reset = 0;
    #1;
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_saved", 32'(saved_flags), 32'h0);
    #2 n_reset = 1;
    #1;
  endtask

  // Architectural rule: cond[3:1] picks a predicate, cond[0] inverts it (except 111x).
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic nf, zf, cf, vf, p;
    {nf, zf, cf, vf} = f;
    case (c[3:1])
      3'd0: p = zf;
      3'd1: p = cf;
      3'd2: p = nf;
      3'd3: p = vf;
      3'd4: p = cf && !zf;
      3'd5: p = (nf == vf);
      3'd6: p = !zf && (nf == vf);
      default: p = 1'b1;
    endcase
    if (c[0] && c[3:1] != 3'd7) p = !p;
    return p;
  endfunction

  typedef struct {
    logic [3:0] c;
    logic [3:0] f;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [3:0] fm, sm;
    int         em, sk;
    logic       lv, ep;

    n_reset = 1;
    idle();
    tick();

    // Reset clears loaded state immediately, no clock edge needed.
    load_flags(4'b1111);
    save_flags = 1; tick(); idle();
    check("preload_flags", 32'(flags), 32'hF);
    check("preload_saved", 32'(saved_flags), 32'hF);
    do_reset();

    // EQ / NE gating.
    load_flags(4'b0100);
    check("load_0100", 32'(flags), 32'h4);
    valid = 1; cond = 4'h0; reg_w = 1; #1;
    check("eq_cond_ex", 32'(cond_ex), 32'h1);
    check("eq_reg_write", 32'(reg_write), 32'h1);
    cond = 4'h1; mem_w = 1; flag_w = 2'b11; alu_flags = 4'hF; #1;
    check("ne_reg_write", 32'(reg_write), 32'h0);
    check("ne_mem_write", 32'(mem_write), 32'h0);
    tick();
    check("ne_flags_kept", 32'(flags), 32'h4);
    idle();

    // CMP: flags update, register write suppressed.
    valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flags = 4'b1001; no_write = 1; reg_w = 1; #1;
    check("cmp_reg_write", 32'(reg_write), 32'h0);
    check("cmp_cond_ex", 32'(cond_ex), 32'h1);
    tick(); idle();
    check("cmp_flags", 32'(flags), 32'h9);
    valid = 1; cond = 4'hB; #1;
    check("lt_after_cmp", 32'(cond_ex), 32'h0);
    cond = 4'hA; #1;
    check("ge_after_cmp", 32'(cond_ex), 32'h1);
    idle();

    // Partial group updates.
    load_flags(4'b0000);
    valid = 1; flag_w = 2'b10; alu_flags = 4'hF; tick();
    check("partial_nz", 32'(flags), 32'hC);
    flag_w = 2'b01; alu_flags = 4'b0011; tick();
    check("partial_cv", 32'(flags), 32'hF);
    idle();

    // Save / restore.
    load_flags(4'b0110);
    save_flags = 1; tick(); idle();
    check("save_copy", 32'(saved_flags), 32'h6);
    load_flags(4'b1001);
    check("overwrite_flags", 32'(flags), 32'h9);
    check("saved_hold", 32'(saved_flags), 32'h6);
    restore_flags = 1; valid = 1; flag_w = 2'b11; alu_flags = 4'h0; tick(); idle();
    check("restore_wins", 32'(flags), 32'h6);
    check("saved_after_restore", 32'(saved_flags), 32'h6);
    load_flags(4'b0011);
    save_flags = 1; restore_flags = 1; tick(); idle();
    check("save_restore_saved", 32'(saved_flags), 32'h6);
    check("save_restore_flags", 32'(flags), 32'h6);

    // Flush and bubble leave everything dead.
    valid = 1; flush = 1; flag_w = 2'b11; alu_flags = 4'hF; pc_s = 1; #1;
    check("flush_cond_ex", 32'(cond_ex), 32'h0);
    check("flush_pc_src", 32'(pc_src), 32'h0);
    tick();
    check("flush_flags", 32'(flags), 32'h6);
    flush = 0; valid = 0; tick();
    check("bubble_flags", 32'(flags), 32'h6);
    idle();

    // Condition table.
    vecs[0]  = '{4'h0, 4'b0100, 1'b1};
    vecs[1]  = '{4'h1, 4'b0100, 1'b0};
    vecs[2]  = '{4'h2, 4'b0010, 1'b1};
    vecs[3]  = '{4'h3, 4'b0010, 1'b0};
    vecs[4]  = '{4'h4, 4'b1000, 1'b1};
    vecs[5]  = '{4'h5, 4'b1000, 1'b0};
    vecs[6]  = '{4'h6, 4'b0001, 1'b1};
    vecs[7]  = '{4'h7, 4'b0000, 1'b1};
    vecs[8]  = '{4'h8, 4'b0010, 1'b1};
    vecs[9]  = '{4'h8, 4'b0110, 1'b0};
    vecs[10] = '{4'h9, 4'b0110, 1'b1};
    vecs[11] = '{4'hA, 4'b1001, 1'b1};
    vecs[12] = '{4'hB, 4'b1000, 1'b1};
    vecs[13] = '{4'hC, 4'b0000, 1'b1};
    vecs[14] = '{4'hC, 4'b0100, 1'b0};
    vecs[15] = '{4'hD, 4'b1000, 1'b1};
    vecs[16] = '{4'hE, 4'b0000, 1'b1};
    vecs[17] = '{4'hF, 4'b0000, 1'b1};
    for (int i = 0; i < 18; i++) begin
      load_flags(vecs[i].f);
      valid = 1; cond = vecs[i].c; pc_s = 1; reg_w = 1; mem_w = 1; #1;
      check($sformatf("tbl%0d_cond_ex", i), 32'(cond_ex), 32'(vecs[i].exp_pass));
      check($sformatf("tbl%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].exp_pass));
      check($sformatf("tbl%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].exp_pass));
      idle();
    end

`ifdef COND_STATS_EN
    // 5 passing, 3 failing, 2 flushed.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      valid = 1;
      cond  = (i < 5) ? 4'hE : 4'h0;   // flags are zero so EQ fails
      flush = (i >= 8);
      tick();
    end
    idle();
    check("stats_exec", 32'(exec_count), 32'd5);
    check("stats_skip", 32'(skip_count), 32'd3);
    do_reset();
    valid = 1; cond = 4'hE;
    for (int i = 0; i < (1 << CW) - 1; i++) tick();
    check("stats_all_ones", 32'(exec_count), 32'((1 << CW) - 1));
    tick();
    check("stats_wrap", 32'(exec_count), 32'd0);
    idle();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    fm = 0; sm = 0; em = 0; sk = 0;
    for (int i = 0; i < 400; i++) begin
      valid         = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 5) == 0);
      cond          = 4'($urandom);
      alu_flags     = 4'($urandom);
      flag_w        = 2'($urandom);
      pc_s          = 1'($urandom);
      reg_w         = 1'($urandom);
      mem_w         = 1'($urandom);
      no_write      = 1'($urandom);
      save_flags    = ($urandom_range(0, 7) == 0);
      restore_flags = ($urandom_range(0, 7) == 0);
      #1;
      lv = valid && !flush;
      ep = lv && ref_pass(cond, fm);
      check("rnd_cond_ex", 32'(cond_ex), 32'(ep));
      check("rnd_pc_src", 32'(pc_src), 32'(ep && pc_s));
      check("rnd_reg_write", 32'(reg_write), 32'(ep && reg_w && !no_write));
      check("rnd_mem_write", 32'(mem_write), 32'(ep && mem_w));
      tick();
      if (ep) em++;
      if (lv && !ep) sk++;
      if (restore_flags) begin
        fm = sm;
      end else begin
        if (save_flags) sm = fm;
        if (ep && flag_w[1]) fm[3:2] = alu_flags[3:2];
        if (ep && flag_w[0]) fm[1:0] = alu_flags[1:0];
      end
      check("rnd_flags", 32'(flags), 32'(fm));
      check("rnd_saved", 32'(saved_flags), 32'(sm));
`ifdef COND_STATS_EN
      check("rnd_exec", 32'(exec_count), 32'(em % (1 << CW)));
      check("rnd_skip", 32'(skip_count), 32'(sk % (1 << CW)));
`endif
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
